// File: rtl/l1_cache_if.sv
// rtl/l1_cache_if.sv - Avalon-MM style word-addressed bus shared by CPU and RAM sides
interface l1_cache_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output read, write, addr, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  read, write, addr, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/l1_cache.sv
// rtl/l1_cache.sv - direct-mapped write-through no-write-allocate L1 cache
module l1_cache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic          clk,
  input  logic          reset,
  l1_cache_if.slave     cpu,
  l1_cache_if.master    ram
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WACK} state_t;

  state_t                   state;
  logic [LINES-1:0]         valid;
  logic [TAG_BITS-1:0]      tag_mem  [LINES];
  logic [31:0]              data_mem [LINES*WORDS];
  logic [31-OFFSET_BITS:0]  line_addr;
  logic [OFFSET_BITS-1:0]   fill_cnt;

  logic [OFFSET_BITS-1:0]   cpu_offset;
  logic [INDEX_BITS-1:0]    cpu_index;
  logic [TAG_BITS-1:0]      cpu_tag;
  logic [INDEX_BITS-1:0]    fill_index;
  logic [TAG_BITS-1:0]      fill_tag;
  logic [OFFSET_BITS-1:0]   next_cnt;
  logic                     hit;

  assign cpu_offset = cpu.addr[OFFSET_BITS-1:0];
  assign cpu_index  = cpu.addr[OFFSET_BITS +: INDEX_BITS];
  assign cpu_tag    = cpu.addr[31 -: TAG_BITS];
  assign fill_index = line_addr[INDEX_BITS-1:0];
  assign fill_tag   = line_addr[31-OFFSET_BITS -: TAG_BITS];
  assign next_cnt   = fill_cnt + OFFSET_BITS'(1);
  assign hit        = valid[cpu_index] && (tag_mem[cpu_index] == cpu_tag);

  // Hits answer in the same cycle; anything else stalls the CPU until the FSM finishes.
  always_comb begin
    cpu.waitrequest = 1'b0;
    cpu.readdata    = '0;
    case (state)
      IDLE: begin
        if (cpu.write || (cpu.read && !hit))
          cpu.waitrequest = 1'b1;
        else if (cpu.read)
          cpu.readdata = data_mem[{cpu_index, cpu_offset}];
      end
      FILL, WRITE: cpu.waitrequest = 1'b1;
      default: cpu.waitrequest = 1'b0;
    endcase
    if (!reset)
      cpu.waitrequest = 1'b0;
  end

  // Line storage carries no reset; only the valid bits decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (state == FILL && !ram.waitrequest) begin
      data_mem[{fill_index, fill_cnt}] <= ram.readdata;
      if (fill_cnt == '1)
        tag_mem[fill_index] <= fill_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      valid          <= '0;
      fill_cnt       <= '0;
      line_addr      <= '0;
      ram.read       <= 1'b0;
      ram.write      <= 1'b0;
      ram.addr       <= '0;
      ram.byteenable <= '0;
      ram.writedata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.write) begin
            if (hit)
              valid[cpu_index] <= 1'b0;
            state          <= WRITE;
            ram.write      <= 1'b1;
            ram.addr       <= cpu.addr;
            ram.byteenable <= cpu.byteenable;
            ram.writedata  <= cpu.writedata;
          end else if (cpu.read && !hit) begin
            state          <= FILL;
            fill_cnt       <= '0;
            line_addr      <= cpu.addr[31:OFFSET_BITS];
            ram.read       <= 1'b1;
            ram.addr       <= {cpu.addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            ram.byteenable <= '1;
          end
        end
        FILL: begin
          if (!ram.waitrequest) begin
            fill_cnt <= next_cnt;
            if (fill_cnt == '1) begin
              valid[fill_index] <= 1'b1;
              state             <= IDLE;
              ram.read          <= 1'b0;
              ram.addr          <= '0;
              ram.byteenable    <= '0;
            end else begin
              ram.addr <= {line_addr, next_cnt};
            end
          end
        end
        WRITE: begin
          if (!ram.waitrequest) begin
            state          <= WACK;
            ram.write      <= 1'b0;
            ram.addr       <= '0;
            ram.byteenable <= '0;
            ram.writedata  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_cache.sv
// tb/tb_l1_cache.sv - randomized scoreboard bench for l1_cache against a line-level reference model
module tb_l1_cache;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_cache_if cpu_bus ();
  l1_cache_if ram_bus ();

  l1_cache #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu_bus),
    .ram   (ram_bus)
  );

  typedef struct {
    bit          is_write;
    logic [31:0] data;
    int          waits;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  exp_t        exp_q [$];
  logic [31:0] fill_q [$];
  wr_t         wr_q [$];

  logic [31:0] ram_mem [1024];
  logic [31:0] ref_mem [1024];
  bit          ref_valid [64];
  logic [23:0] ref_tag [64];

  int checks = 0;
  int errors = 0;
  int wait_cnt = 0;

  assign ram_bus.readdata = ram_mem[ram_bus.addr[9:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int stall, input logic [31:0] stall_addr);
    int n = 0;
    int stall_left = stall;
    bit stalling = 0;
    forever begin
      @(negedge clk);
      if (stalling) begin
        check("stall read_ram held", ram_bus.read, 1);
        check("stall addr_ram held", ram_bus.addr, stall_addr);
        check("stall waitrequest_cpu", cpu_bus.waitrequest, 1);
      end
      if (!cpu_bus.waitrequest) break;
      n++;
      if (n > 60) begin
        check("request done within budget", cpu_bus.waitrequest, 0);
        break;
      end
      @(posedge clk); #1;
      if (stall_left > 0 && ram_bus.read && ram_bus.addr == stall_addr) begin
        ram_bus.waitrequest = 1'b1;
        stall_left--;
        stalling = 1;
      end else begin
        ram_bus.waitrequest = 1'b0;
        stalling = 0;
      end
    end
    @(posedge clk); #1;
    cpu_bus.read  = 1'b0;
    cpu_bus.write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int stall);
    int   idx = int'(a[7:2]);
    bit   hit = ref_valid[idx] && ref_tag[idx] == a[31:8];
    exp_t e;
    logic [31:0] base = {a[31:2], 2'b00};
    if (!hit) begin
      for (int k = 0; k < 4; k++) fill_q.push_back(base + k);
      ref_valid[idx] = 1;
      ref_tag[idx]   = a[31:8];
    end
    e.is_write = 0;
    e.data     = ref_mem[a[9:0]];
    e.waits    = hit ? 0 : 5 + stall;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cpu_bus.read = 1'b1;
    cpu_bus.addr = a;
    wait_done(stall, base + 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int   idx = int'(a[7:2]);
    exp_t e;
    wr_t  w;
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[9:0]][8*b +: 8] = d[8*b +: 8];
    if (ref_valid[idx] && ref_tag[idx] == a[31:8]) ref_valid[idx] = 0;
    w.addr = a; w.data = d; w.be = be;
    wr_q.push_back(w);
    e.is_write = 1; e.data = '0; e.waits = 2;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cpu_bus.write      = 1'b1;
    cpu_bus.addr       = a;
    cpu_bus.writedata  = d;
    cpu_bus.byteenable = be;
    wait_done(0, '0);
  endtask

  task automatic abort_fill(input logic [31:0] a);
    int n = 0;
    logic [31:0] base = {a[31:2], 2'b00};
    for (int k = 0; k < 4; k++) fill_q.push_back(base + k);
    @(posedge clk); #1;
    cpu_bus.read = 1'b1;
    cpu_bus.addr = a;
    while (!(ram_bus.read && ram_bus.addr == base + 2) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("fill reached word 2", ram_bus.addr, base + 2);
    reset = 1'b0;
    #1;
    check("abort read_ram dropped", ram_bus.read, 0);
    check("abort waitrequest_cpu", cpu_bus.waitrequest, 0);
    cpu_bus.read = 1'b0;
    fill_q.delete();
    for (int i = 0; i < 64; i++) ref_valid[i] = 0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Transaction-level monitor: every completed CPU request is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        wait_cnt = 0;
      end else if (cpu_bus.read || cpu_bus.write) begin
        if (cpu_bus.waitrequest) begin
          wait_cnt++;
        end else begin
          check("completion expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wait cycles", wait_cnt, e.waits);
            if (!e.is_write) check("readdata_cpu", cpu_bus.readdata, e.data);
          end
          wait_cnt = 0;
        end
      end
    end
  end

  // RAM-side monitor: fill order, write forwarding, and the RAM contents themselves.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (reset && ram_bus.read && ram_bus.write)
        check("read_ram and write_ram exclusive", 1'b1, 1'b0);
      if (reset && ram_bus.read && !ram_bus.waitrequest) begin
        check("ram read expected", fill_q.size() > 0, 1);
        if (fill_q.size() > 0) check("fill addr_ram", ram_bus.addr, fill_q.pop_front());
        check("fill byteenable_ram", ram_bus.byteenable, 4'hF);
      end
      if (reset && ram_bus.write && !ram_bus.waitrequest) begin
        check("ram write expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("write addr_ram", ram_bus.addr, w.addr);
          check("writedata_ram", ram_bus.writedata, w.data);
          check("write byteenable_ram", ram_bus.byteenable, w.be);
        end
        for (int b = 0; b < 4; b++)
          if (ram_bus.byteenable[b])
            ram_mem[ram_bus.addr[9:0]][8*b +: 8] = ram_bus.writedata[8*b +: 8];
      end
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'(16 * i + 1);
      ref_mem[i] = 32'(16 * i + 1);
    end
    for (int i = 0; i < 64; i++) ref_valid[i] = 0;
    reset               = 1'b0;
    cpu_bus.read        = 1'b0;
    cpu_bus.write       = 1'b0;
    cpu_bus.addr        = '0;
    cpu_bus.byteenable  = '0;
    cpu_bus.writedata   = '0;
    ram_bus.waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset read_ram", ram_bus.read, 0);
    check("reset write_ram", ram_bus.write, 0);
    check("reset waitrequest_cpu", cpu_bus.waitrequest, 0);
    check("reset addr_ram", ram_bus.addr, 0);
    check("reset byteenable_ram", ram_bus.byteenable, 0);
    check("reset writedata_ram", ram_bus.writedata, 0);
    check("reset readdata_cpu", cpu_bus.readdata, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    do_read(32'd16, 0);
    do_read(32'd17, 0);
    do_read(32'd22, 0);
    do_read(32'd23, 0);
    do_write(32'd17, 32'hDEADBEEF, 4'h3);
    do_read(32'd17, 0);
    do_read(32'd16, 0);
    do_read(32'd272, 0);
    do_read(32'd16, 0);
    do_read(32'd400, 3);
    do_read(32'd401, 0);
    do_write(32'd500, 32'h12345678, 4'hF);
    do_read(32'd500, 0);
    abort_fill(32'd600);
    do_read(32'd600, 0);
    do_read(32'd16, 0);

    for (int t = 0; t < 300; t++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)));
      else
        do_read(a, 0);
    end

    repeat (5) @(posedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    check("fill queue drained", fill_q.size(), 0);
    check("write queue drained", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 cache between the CPU data port and RAM.
- Both ports use an Avalon-MM style interface with read/write/waitrequest handshakes.
- Read hits return data combinationally with no wait states.
- Read misses fill a whole 4-word line from RAM.
- Writes are forwarded to RAM and invalidate any matching cached line.

Parameters:
- INDEX_BITS, 6, log2 of number of lines (64 lines).
- OFFSET_BITS, 2, log2 of words per line (4 words).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- read_cpu  input  1  CPU read request.
- write_cpu  input  1  CPU write request.
- addr_cpu  input  32  CPU word address.
- byteenable_cpu  input  4  CPU byte lanes.
- writedata_cpu  input  32  CPU write data.
- readdata_cpu  output  32  read data to CPU.
- waitrequest_cpu  output  1  high = CPU request not yet complete.
- read_ram  output  1  RAM read request.
- write_ram  output  1  RAM write request.
- addr_ram  output  32  RAM word address.
- byteenable_ram  output  4  RAM byte lanes.
- writedata_ram  output  32  RAM write data.
- readdata_ram  input  32  RAM read data.
- waitrequest_ram  input  1  high = RAM stalls the current request.

Behaviour:
- Addressing (addresses are word indices):
  - offset = addr[1:0].
  - index = addr[7:2].
  - tag = addr[31:8].
- Storage:
  - Per line: valid bit, 24-bit tag, 4x32 data.
  - Only the valid bits are reset; tags and data are not.
- Reset (reset=0, asynchronous):
  - All valid bits are cleared and state goes to IDLE.
  - read_ram, write_ram and waitrequest_cpu are 0.
  - addr_ram, byteenable_ram, writedata_ram and readdata_cpu are 0.
  - A reset during a fill or write aborts it; the partially filled line stays invalid.
- Hit: valid[index] and tag match.
- IDLE state:
  - Read hit:
    - readdata_cpu = data[index][offset], driven combinationally.
    - waitrequest_cpu=0; the transaction completes at the same edge.
    - No RAM access.
  - Read miss:
    - waitrequest_cpu=1 combinationally.
    - Next state FILL with fill counter=0, latching the line base {addr_cpu[31:2],2'b00}.
  - Write:
    - waitrequest_cpu=1 and next state WRITE.
    - If the line hits, its valid bit is cleared at this edge.
  - Both read_cpu and write_cpu high: treated as a write.
  - Idle with no request: waitrequest_cpu=0.
- FILL state:
  - read_ram=1, addr_ram=base+counter, byteenable_ram=4'hF, waitrequest_cpu=1.
  - At an edge with waitrequest_ram=0: readdata_ram is written into data[index][counter] and the counter increments.
  - While waitrequest_ram=1, outputs are held stable.
  - After word 3 is accepted: tag is written, valid is set, next state IDLE.
  - The pending read then hits in the following cycle.
  - Words are fetched in order 0,1,2,3.
- WRITE state:
  - write_ram=1, with addr_ram=addr_cpu, writedata_ram=writedata_cpu, byteenable_ram=byteenable_cpu.
  - waitrequest_cpu=1.
  - When waitrequest_ram=0 at an edge, next state is WACK.
- WACK state: waitrequest_cpu=0 for one cycle (CPU write completes), then IDLE.
- Outside FILL/WRITE, read_ram and write_ram are 0.
- The CPU must hold its request stable while waitrequest_cpu=1.
- Latency with a zero-wait RAM:
  - Read hit: 0 wait cycles.
  - Read miss: 5 wait cycles (1 detect + 4 fill); data is returned in the 6th cycle.
  - Write: 2 wait cycles.
- Only one outstanding request at a time.
- There is no dirty state and no write-back.

Test Plan:
- Bench model: RAM mem[i]=16*i+1, combinational readdata_ram=mem[addr_ram], waitrequest_ram=0.
- Cold read miss: reset, then read addr 16 -> read_ram issued for addrs 16,17,18,19 on consecutive cycles; waitrequest_cpu high 5 cycles, then low with readdata_cpu=257.
- Hits in the cached block:
  - Read addr 17 after the previous fill -> waitrequest_cpu=0 same cycle, readdata_cpu=273, read_ram stays 0.
  - Read addr 22 -> miss fetching 20..23, then readdata_cpu=353.
  - Read addr 23 -> immediate hit 369.
- Write invalidation:
  - Write addr 17 data 0xDEADBEEF, byteenable 4'h3 -> write_ram with addr 17, same data and byteenable; waitrequest_cpu low in the 3rd cycle.
  - A subsequent read of 17 misses and refetches 16..19.
- Conflict miss: read 16 (fill), read 272 (same index, different tag; fill 272..275, data 4353), read 16 again -> miss and refetch.
- RAM stall: waitrequest_ram held high 3 cycles during word 1 of a fill -> read_ram=1 and addr_ram held constant, waitrequest_cpu stays high, fill resumes correctly.
- Reset mid-fill: assert reset during word 2 of a fill -> read_ram drops immediately; after release, the same read misses again.
